// File: rtl/core_pkg.sv
// Shared types and constants for the Beta pipeline hazard/bypass logic.
package core_pkg;

    localparam int REG_AW = 5;
    localparam int XLEN   = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd31;

    // One in-flight instruction as seen by the scoreboard.
    typedef struct packed {
        logic              valid;
        logic              we;
        logic [REG_AW-1:0] waddr;
        logic              load;
    } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Per-read-port priority compare over the scoreboard: picks the youngest
// producer, forwards its stage result, or flags a load-use hazard.
import core_pkg::*;

module hazard_match #(
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2
) (
    input  sb_entry_t [DEPTH-1:0]      sb_i,
    input  logic [REG_AW-1:0]          rd_addr_i,
    input  logic [XLEN-1:0]            rf_data_i,
    input  logic [DEPTH*XLEN-1:0]      stage_data_i,
    output logic [XLEN-1:0]            rd_data_o,
    output logic                       hazard_o
);

    always_comb begin
        logic found;
        found     = 1'b0;
        rd_data_o = rf_data_i;
        hazard_o  = 1'b0;
        // Ascending scan with a found flag: the first (youngest) hit wins.
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && sb_i[k].valid && sb_i[k].we &&
                sb_i[k].waddr == rd_addr_i && rd_addr_i != REG_ZERO) begin
                found     = 1'b1;
                rd_data_o = stage_data_i[k*XLEN +: XLEN];
                if (sb_i[k].load && k < LOAD_STAGE) begin
                    hazard_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Scoreboard-based hazard and bypass controller for DEPTH stages and NUM_RD ports.
// Optional stall-cycle counter enabled by defining HAZARD_PERF_CNT_EN.
import core_pkg::*;

module hazard_unit #(
    parameter int NUM_RD     = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iss_valid,
    input  logic                     iss_we,
    input  logic [REG_AW-1:0]        iss_waddr,
    input  logic                     iss_load,
    input  logic                     flush,
    input  logic [NUM_RD*REG_AW-1:0] rd_addr,
    input  logic [NUM_RD*XLEN-1:0]   rf_data,
    input  logic [DEPTH*XLEN-1:0]    stage_data,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    output logic                     stall,
    output logic                     wb_we,
    output logic [REG_AW-1:0]        wb_waddr,
    output logic [31:0]              perf_stall_cnt
);

    sb_entry_t [DEPTH-1:0] sb_q;
    sb_entry_t [DEPTH-1:0] sb_d;
    logic [NUM_RD-1:0]     hazard;

    // Non-issuing slots are inserted fully zeroed so retired fields stay clean.
    always_comb begin
        sb_d[0] = '0;
        if (iss_valid && !flush && !stall) begin
            sb_d[0].valid = 1'b1;
            sb_d[0].we    = iss_we && (iss_waddr != REG_ZERO);
            sb_d[0].waddr = iss_waddr;
            sb_d[0].load  = iss_load;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_shift
            assign sb_d[gi] = sb_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_port
            hazard_match #(
                .DEPTH      (DEPTH),
                .LOAD_STAGE (LOAD_STAGE)
            ) u_match (
                .sb_i         (sb_q),
                .rd_addr_i    (rd_addr[gi*REG_AW +: REG_AW]),
                .rf_data_i    (rf_data[gi*XLEN +: XLEN]),
                .stage_data_i (stage_data),
                .rd_data_o    (rd_data[gi*XLEN +: XLEN]),
                .hazard_o     (hazard[gi])
            );
        end
    endgenerate

    assign stall    = |hazard;
    assign wb_we    = sb_q[DEPTH-1].valid && sb_q[DEPTH-1].we;
    assign wb_waddr = sb_q[DEPTH-1].waddr;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt_q <= '0;
        end else if (stall) begin
            perf_cnt_q <= perf_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_cnt_q;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule
